// File: rtl/intra_net_tile_sched.sv
// Tile sequencer for the intra-net transpose/relayout unit: accepts a job, issues one start per tile, advances bases.
// Optional per-tile watchdog enabled by defining INTRA_SCHED_TIMEOUT_EN.
module intra_net_tile_sched #(
    parameter int COL_DIM        = 16,
    parameter int ADDR_WIDTH     = 10,
    parameter int TILE_CNT_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [$clog2(COL_DIM):0]    cmd_A,
    input  logic [$clog2(COL_DIM):0]    cmd_B,
    input  logic [ADDR_WIDTH-1:0]       cmd_O_base,
    input  logic [ADDR_WIDTH-1:0]       cmd_A_base,
    input  logic [ADDR_WIDTH-1:0]       cmd_O_stride,
    input  logic [ADDR_WIDTH-1:0]       cmd_A_stride,
    input  logic [TILE_CNT_WIDTH-1:0]   cmd_tiles,
    output logic                        net_start,
    output logic [$clog2(COL_DIM):0]    net_A,
    output logic [$clog2(COL_DIM):0]    net_B,
    output logic [ADDR_WIDTH-1:0]       net_O_base_addr,
    output logic [ADDR_WIDTH-1:0]       net_A_base_addr,
    input  logic                        net_end,
    output logic                        busy,
    output logic [TILE_CNT_WIDTH-1:0]   tile_idx,
    output logic                        done,
    output logic                        err
);

    localparam int DIM_W = $clog2(COL_DIM) + 1;
    localparam logic [DIM_W-1:0] MAX_DIM = DIM_W'(COL_DIM);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] NEXT  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]                state;
    logic [ADDR_WIDTH-1:0]     o_stride;
    logic [ADDR_WIDTH-1:0]     a_stride;
    logic [TILE_CNT_WIDTH-1:0] tiles;
    logic                      err_r;
    logic                      dim_bad;
    logic                      last_tile;

`ifdef INTRA_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] wait_cnt;
`endif

    assign dim_bad   = (cmd_A == '0) || (cmd_A > MAX_DIM) || (cmd_B == '0) || (cmd_B > MAX_DIM);
    assign last_tile = (tile_idx == tiles - TILE_CNT_WIDTH'(1));

    assign cmd_ready = (state == IDLE);
    assign net_start = (state == ISSUE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign err       = done && err_r;

    // Config registers only move on accept or in NEXT, so the unit sees stable values for a whole tile.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            net_A           <= '0;
            net_B           <= '0;
            net_O_base_addr <= '0;
            net_A_base_addr <= '0;
            o_stride        <= '0;
            a_stride        <= '0;
            tiles           <= '0;
            tile_idx        <= '0;
            err_r           <= 1'b0;
`ifdef INTRA_SCHED_TIMEOUT_EN
            wait_cnt        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        net_A           <= cmd_A;
                        net_B           <= cmd_B;
                        net_O_base_addr <= cmd_O_base;
                        net_A_base_addr <= cmd_A_base;
                        o_stride        <= cmd_O_stride;
                        a_stride        <= cmd_A_stride;
                        tiles           <= cmd_tiles;
                        tile_idx        <= '0;
                        err_r           <= dim_bad;
                        if (dim_bad || cmd_tiles == '0) begin
                            state <= DONE;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef INTRA_SCHED_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                WAIT: begin
                    // A real end pulse wins over a watchdog expiry landing in the same cycle.
                    if (net_end) begin
                        state <= last_tile ? DONE : NEXT;
`ifdef INTRA_SCHED_TIMEOUT_EN
                    end else if (wait_cnt == TO_LIMIT) begin
                        err_r <= 1'b1;
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
`endif
                    end
                end
                NEXT: begin
                    net_O_base_addr <= net_O_base_addr + o_stride;
                    net_A_base_addr <= net_A_base_addr + a_stride;
                    tile_idx        <= tile_idx + TILE_CNT_WIDTH'(1);
                    state           <= ISSUE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intra_net_tile_sched.sv
// Directed, table-driven bench for intra_net_tile_sched; timeout vector added when INTRA_SCHED_TIMEOUT_EN is defined.
module tb_intra_net_tile_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [4:0] cmd_A, cmd_B;
    logic [9:0] cmd_O_base, cmd_A_base, cmd_O_stride, cmd_A_stride;
    logic [7:0] cmd_tiles;
    logic       net_start;
    logic [4:0] net_A, net_B;
    logic [9:0] net_O_base_addr, net_A_base_addr;
    logic       net_end;
    logic       busy;
    logic [7:0] tile_idx;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    intra_net_tile_sched #(
        .COL_DIM(16), .ADDR_WIDTH(10), .TILE_CNT_WIDTH(8), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_A(cmd_A), .cmd_B(cmd_B),
        .cmd_O_base(cmd_O_base), .cmd_A_base(cmd_A_base),
        .cmd_O_stride(cmd_O_stride), .cmd_A_stride(cmd_A_stride),
        .cmd_tiles(cmd_tiles),
        .net_start(net_start), .net_A(net_A), .net_B(net_B),
        .net_O_base_addr(net_O_base_addr), .net_A_base_addr(net_A_base_addr),
        .net_end(net_end), .busy(busy), .tile_idx(tile_idx),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] a;
        logic [4:0] b;
        logic [9:0] o_base;
        logic [9:0] a_base;
        logic [9:0] o_stride;
        logic [9:0] a_stride;
        logic [7:0] tiles;
        int         end_delay;
        bit         spurious;
        bit         keep_valid;
        bit         exp_err;
        int         exp_starts;
        logic [9:0] exp_last_o;
        logic [9:0] exp_last_a;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Drives one job and plays the unit: a start is answered with net_end end_delay cycles later (0 = never).
    task automatic applyStimulus(input vec_t v, input string tag);
        int         cyc;
        int         starts;
        int         countdown;
        int         last_end;
        int         last_start;
        bit         finished;
        logic [9:0] eo;
        logic [9:0] ea;
        checkOutput({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        cmd_A        = v.a;
        cmd_B        = v.b;
        cmd_O_base   = v.o_base;
        cmd_A_base   = v.a_base;
        cmd_O_stride = v.o_stride;
        cmd_A_stride = v.a_stride;
        cmd_tiles    = v.tiles;
        cmd_valid    = 1'b1;
        nextCycle();
        cyc = 1;
        if (v.keep_valid) begin
            cmd_O_base = ~v.o_base;
            cmd_tiles  = 8'hFF;
            cmd_A      = 5'd0;
        end else begin
            cmd_valid = 1'b0;
        end
        starts     = 0;
        countdown  = 0;
        last_end   = -100;
        last_start = -100;
        finished   = 1'b0;
        eo         = v.o_base;
        ea         = v.a_base;
        while (!finished && cyc < 300) begin
            net_end = 1'b0;
            if (done) begin
                checkOutput({tag, "_err"}, 32'(err), 32'(v.exp_err));
                checkOutput({tag, "_starts"}, 32'(starts), 32'(v.exp_starts));
                checkOutput({tag, "_busy_done"}, 32'(busy), 32'd1);
                if (starts == 0)
                    checkOutput({tag, "_done_cycle"}, 32'(cyc), 32'd1);
                else if (v.end_delay == 0)
                    checkOutput({tag, "_timeout_cycle"}, 32'(cyc), 32'(last_start + 9));
                else
                    checkOutput({tag, "_done_cycle"}, 32'(cyc), 32'(last_end + 1));
                if (starts > 0) begin
                    checkOutput({tag, "_last_O"}, 32'(net_O_base_addr), 32'(v.exp_last_o));
                    checkOutput({tag, "_last_A"}, 32'(net_A_base_addr), 32'(v.exp_last_a));
                end
                finished = 1'b1;
            end else if (net_start) begin
                eo = 10'(v.o_base + 10'(v.o_stride * 10'(starts)));
                ea = 10'(v.a_base + 10'(v.a_stride * 10'(starts)));
                checkOutput({tag, "_tile_O"}, 32'(net_O_base_addr), 32'(eo));
                checkOutput({tag, "_tile_A"}, 32'(net_A_base_addr), 32'(ea));
                checkOutput({tag, "_tile_idx"}, 32'(tile_idx), 32'(starts));
                checkOutput({tag, "_dims"}, 32'({net_A, net_B}), 32'({v.a, v.b}));
                if (starts == 0)
                    checkOutput({tag, "_first_start"}, 32'(cyc), 32'd1);
                else
                    checkOutput({tag, "_start_gap"}, 32'(cyc), 32'(last_end + 2));
                starts++;
                last_start = cyc;
                countdown  = v.end_delay;
                net_end    = v.spurious;
            end else if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    net_end  = 1'b1;
                    last_end = cyc;
                    checkOutput({tag, "_hold"}, 32'({net_O_base_addr, net_A_base_addr}), 32'({eo, ea}));
                end
            end
            nextCycle();
            cyc++;
        end
        net_end = 1'b0;
        if (!finished) begin
            failures++;
            $display("[TB] FAIL %s_no_done actual=timeout expected=done", tag);
        end
        checkOutput({tag, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_pulses"}, 32'({net_start, done, err}), 32'd0);
        checkOutput({tag, "_cfg"}, 32'({net_A, net_B, net_O_base_addr, net_A_base_addr}), 32'd0);
        checkOutput({tag, "_tile_idx"}, 32'(tile_idx), 32'd0);
    endtask

    initial begin
        int dones;
        int waited;
        reset        = 1'b1;
        cmd_valid    = 1'b0;
        cmd_A        = '0;
        cmd_B        = '0;
        cmd_O_base   = '0;
        cmd_A_base   = '0;
        cmd_O_stride = '0;
        cmd_A_stride = '0;
        cmd_tiles    = '0;
        net_end      = 1'b0;

        //                a      b      o_base  a_base  o_str   a_str   tiles  dly sp kv err st lastO   lastA
        vecs.push_back('{5'd16, 5'd16, 10'h010, 10'h200, 10'h000, 10'h000, 8'd1, 20, 0, 0, 0, 1, 10'h010, 10'h200});
        vecs.push_back('{5'd16, 5'd16, 10'h010, 10'h200, 10'h040, 10'h010, 8'd3,  5, 0, 0, 0, 3, 10'h090, 10'h220});
        vecs.push_back('{5'd8,  5'd4,  10'h000, 10'h3F8, 10'h000, 10'h010, 8'd2,  2, 0, 0, 0, 2, 10'h000, 10'h008});
        vecs.push_back('{5'd0,  5'd4,  10'h001, 10'h002, 10'h003, 10'h004, 8'd2,  2, 0, 0, 1, 0, 10'h000, 10'h000});
        vecs.push_back('{5'd4,  5'd17, 10'h001, 10'h002, 10'h003, 10'h004, 8'd2,  2, 0, 0, 1, 0, 10'h000, 10'h000});
        vecs.push_back('{5'd16, 5'd1,  10'h001, 10'h002, 10'h003, 10'h004, 8'd0,  2, 0, 0, 0, 0, 10'h000, 10'h000});
        vecs.push_back('{5'd1,  5'd1,  10'h3C0, 10'h100, 10'h050, 10'h001, 8'd2,  3, 1, 1, 0, 2, 10'h010, 10'h101});
        vecs.push_back('{5'd16, 5'd1,  10'h123, 10'h045, 10'h001, 10'h001, 8'd1,  1, 0, 0, 0, 1, 10'h123, 10'h045});
`ifdef INTRA_SCHED_TIMEOUT_EN
        vecs.push_back('{5'd4,  5'd4,  10'h020, 10'h030, 10'h100, 10'h100, 8'd3,  0, 0, 0, 1, 1, 10'h020, 10'h030});
`endif

        nextCycle();
        checkResetState("reset");
        nextCycle();
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while the unit is working on a tile must abandon the job silently.
        cmd_A        = 5'd4;
        cmd_B        = 5'd4;
        cmd_O_base   = 10'h111;
        cmd_A_base   = 10'h222;
        cmd_O_stride = 10'h010;
        cmd_A_stride = 10'h010;
        cmd_tiles    = 8'd3;
        cmd_valid    = 1'b1;
        nextCycle();
        cmd_valid = 1'b0;
        waited    = 0;
        while (!net_start && waited < 20) begin
            nextCycle();
            waited++;
        end
        checkOutput("midrst_started", 32'(waited), 32'd0);
        nextCycle();
        nextCycle();
        checkOutput("midrst_busy_wait", 32'(busy), 32'd1);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        checkResetState("midrst");
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) dones++;
            nextCycle();
        end
        checkOutput("midrst_no_done", 32'(dones), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
